pwm16_gen: RTL
==============

# pwm16_gen

Double-buffered 16-bit PWM generator that sits directly downstream of the `cnt16` free-running counter. It consumes the counter value and its `full` flag, and compares the count against an active duty register to produce a registered PWM output. New duty values are held in a shadow register and applied only at the counter wrap, so each PWM period is glitch-free. It also emits a per-period pulse and a wrapping period count for software and status logic.

## Interface
- No parameters. Width is fixed at 16 to match `cnt16`.
- `CLK` in, 1: system clock. Same clock as `cnt16`.
- `CLRN` in, 1: asynchronous active-low reset.
- `cnt` in, 16: counter value, driven by `cnt16` `Q`.
- `full` in, 1: high when `cnt == 16'hFFFF`, driven by `cnt16` `full`.
- `en` in, 1: PWM enable.
- `duty_wr` in, 1: single-cycle write strobe for `duty_in`.
- `duty_in` in, 16: new compare value (duty = `duty_in` / 65536).
- `pwm` out, 1: registered PWM output.
- `pend` out, 1: a shadow value is waiting to be applied at the next wrap.
- `period_done` out, 1: one-cycle pulse in the cycle after each wrap.
- `per_cnt` out, 8: number of completed periods while enabled; wraps from FF to 00.

## Operation
Internal registers:
- `cmp_sh` (16): shadow duty value.
- `cmp_act` (16): active duty value.
- Both reset to 0.

Duty write (`duty_wr`=1, `full`=0):
- `cmp_sh` <= `duty_in`.
- `pend` <= 1.
- `cmp_act` is unchanged, so the current period is unaffected.

Wrap (`full`=1, `duty_wr`=0):
- `cmp_act` <= `cmp_sh`.
- `pend` <= 0.

Simultaneous write and wrap (`duty_wr`=1 and `full`=1):
- `duty_in` is loaded into both `cmp_sh` and `cmp_act`.
- `pend` <= 0.
- The written value takes effect in the period starting next cycle.

Back-to-back writes before a wrap: the last write wins and `pend` stays 1.

PWM compare:
- Every edge, `pwm` <= `en` & (`cnt` < `cmp_act`), as an unsigned 16-bit compare.
- `cmp_act`=0 gives `pwm` constantly 0.
- `cmp_act`=FFFF gives `pwm` high for 65535 of every 65536 cycles. It is low only for the sample taken at `cnt`=FFFF.
- 100% duty is not representable; this is intentional.

Period tracking:
- `period_done` <= `full`, independent of `en`.
- `per_cnt` <= `per_cnt` + 1 on `full` & `en`. It wraps modulo 256.
- `en`=0 holds `per_cnt`.

The duty path (`cmp_sh`, `cmp_act`, `pend`) operates regardless of `en`.

## Timing
Reset (`CLRN` low):
- `pwm`=0, `pend`=0, `period_done`=0, `per_cnt`=0, `cmp_sh`=0, `cmp_act`=0.
- All take effect immediately and asynchronously, including mid-period.

Output latency:
- `pwm` lags `cnt` by one cycle. The `pwm` value seen while `cnt`=N+1 reflects the sample at `cnt`=N.
- `period_done` is high exactly in the cycle where `cnt`=0000 following a wrap.

Duty update timing:
- A duty written at any cycle with `full`=0 first affects `pwm` at the edge after the next wrap. That is the first sample of `cnt`=0000, visible one cycle later.

Enable timing:
- Deasserting `en` forces `pwm` low at the next edge.
- Reasserting `en` resumes mid-period using the current `cmp_act`, with no resync.

No handshake back-pressure: `duty_wr` is always accepted.

## Test plan
- Reset check: hold `CLRN`=0, then release with `cnt16` starting at 0 -> `pwm`=0, `pend`=0, `per_cnt`=00 and `period_done`=0 before the first wrap.
- Write-then-wrap: `en`=1, write `duty_in`=0x4000 at `cnt`=0x0010 -> `pend`=1 and `pwm` stays 0 for the rest of that period. After the wrap, `pend`=0 and `pwm` is high for exactly 16384 cycles of the next period.
- Simultaneous write and wrap: write 0x8000 in the cycle `full`=1 -> `pend` stays 0 and the next period shows exactly 32768 high cycles.
- Boundary duties: `cmp_act`=0x0000 gives 0 high cycles per period; 0xFFFF gives 65535 high cycles; 0x0001 gives exactly 1 high cycle, in the cycle with `cnt`=0x0001.
- Period counting: `en`=1 for 3 wraps -> 3 `period_done` pulses and `per_cnt`=03. Then `en`=0 for 1 wrap -> `period_done` still pulses, `per_cnt` stays 03, and `pwm` stays 0.
- Reset mid-period: with `cmp_act`=0x8000, `pwm` high, and `pend`=1, assert `CLRN` at `cnt`=0x0100 -> all outputs go to 0 immediately. After release, `pwm` stays 0 through the following full period because `cmp_act`=0.

Source files
------------

// File: rtl/pwm16_gen.sv
`default_nettype none
// ============================================================================
//  Module   : pwm16_gen
//  Brief    : Double-buffered 16-bit PWM generator fed by the cnt16 counter.
//             The duty is written into a shadow register and moved into the
//             active compare register only at the counter wrap. Also produces
//             a per-period pulse and an 8-bit count of completed enabled periods.
//  Revision : 1.0 - initial release
// ============================================================================
module pwm16_gen (
  input  logic        CLK,
  input  logic        CLRN,
  input  logic [15:0] cnt,
  input  logic        full,
  input  logic        en,
  input  logic        duty_wr,
  input  logic [15:0] duty_in,
  output logic        pwm,
  output logic        pend,
  output logic        period_done,
  output logic [7:0]  per_cnt
);

  logic [15:0] r_cmp_sh;
  logic [15:0] r_cmp_act;
  logic        r_pend;
  logic        r_pwm;
  logic        r_period_done;
  logic [7:0]  r_per_cnt;
  logic        w_below;

  // Compare uses the active value as it stands this cycle. A new value loaded
  // at the wrap edge therefore first applies to the cnt=0000 sample.
  assign w_below = (cnt < r_cmp_act);

  // Shadow/active duty registers. A write that coincides with the wrap goes
  // straight into both registers, so nothing is left pending.
  always_ff @(posedge CLK or negedge CLRN) begin
    if (!CLRN) begin
      r_cmp_sh  <= 16'h0000;
      r_cmp_act <= 16'h0000;
      r_pend    <= 1'b0;
    end else if (duty_wr) begin
      r_cmp_sh <= duty_in;
      if (full) begin
        r_cmp_act <= duty_in;
        r_pend    <= 1'b0;
      end else begin
        r_pend    <= 1'b1;
      end
    end else if (full) begin
      r_cmp_act <= r_cmp_sh;
      r_pend    <= 1'b0;
    end
  end

  // Registered PWM output, gated by the enable.
  always_ff @(posedge CLK or negedge CLRN) begin
    if (!CLRN) begin
      r_pwm <= 1'b0;
    end else begin
      r_pwm <= en & w_below;
    end
  end

  // Period pulse follows the wrap regardless of enable; the period count only
  // advances while enabled and wraps naturally modulo 256.
  always_ff @(posedge CLK or negedge CLRN) begin
    if (!CLRN) begin
      r_period_done <= 1'b0;
      r_per_cnt     <= 8'h00;
    end else begin
      r_period_done <= full;
      if (full && en) begin
        r_per_cnt <= r_per_cnt + 8'd1;
      end
    end
  end

  assign pwm         = r_pwm;
  assign pend        = r_pend;
  assign period_done = r_period_done;
  assign per_cnt     = r_per_cnt;

endmodule
`default_nettype wire
